// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: 2*RADIX-bit dividend by RADIX-bit divisor,
// one quotient bit per clock, with divide-by-zero and quotient-overflow short cuts.
module div_seq #(
    parameter int RADIX = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*RADIX-1:0]   A,
    input  logic [RADIX-1:0]     B,
    output logic                 ready,
    output logic                 valid,
    output logic [RADIX-1:0]     Q,
    output logic [RADIX-1:0]     R,
    output logic                 div_by_zero,
    output logic                 overflow
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // CALC  | one restoring step per cycle, RADIX steps
    // DONE  | one-cycle valid pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (RADIX > 1) ? $clog2(RADIX) : 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RADIX-1:0]   rem_q, rem_d;
    logic [RADIX-1:0]   shift_q, shift_d;
    logic [RADIX-1:0]   b_q, b_d;
    logic [RADIX-1:0]   quo_q, quo_d;
    logic [RADIX-1:0]   res_r_q, res_r_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [RADIX-1:0]   a_hi, a_lo;
    logic               accept;
    logic               b_zero;
    logic               a_ovf;
    logic               last_iter;
    logic [RADIX:0]     trial;
    logic [RADIX-1:0]   diff;
    logic               q_bit;

    assign a_hi      = A[2*RADIX-1:RADIX];
    assign a_lo      = A[RADIX-1:0];
    assign accept    = (state_q == IDLE) && start;
    assign b_zero    = (B == '0);
    assign a_ovf     = (a_hi >= B);
    assign last_iter = (cnt_q == CW'(RADIX - 1));

    // rem_q < b_q holds before every step, so its would-be top bit is always 0
    // and the remainder register only needs RADIX bits.
    assign trial = {rem_q, shift_q[RADIX-1]};
    assign q_bit = (trial >= {1'b0, b_q});
    assign diff  = trial[RADIX-1:0] - b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (b_zero || a_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        b_d     = b_q;
        quo_d   = quo_q;
        res_r_d = res_r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        if (accept) begin
            b_d   = B;
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            if (b_zero) begin
                quo_d   = '1;
                res_r_d = a_lo;
                dbz_d   = 1'b1;
            end else if (a_ovf) begin
                quo_d   = '1;
                res_r_d = '0;
                ovf_d   = 1'b1;
            end else begin
                rem_d   = a_hi;
                shift_d = a_lo;
                cnt_d   = '0;
            end
        end else if (state_q == CALC) begin
            rem_d   = q_bit ? diff : trial[RADIX-1:0];
            shift_d = {shift_q[RADIX-2:0], q_bit};
            cnt_d   = cnt_q + CW'(1);
            if (last_iter) begin
                quo_d   = shift_d;
                res_r_d = rem_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            res_r_q <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            res_r_q <= res_r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q           = quo_q;
    assign R           = res_r_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
